// File: rtl/rv32_pipe_pkg.sv
// Shared RV32IM pipeline types and constants.
// Widths, register x0 and the ID/EX bundle with its bubble value.
package rv32_pipe_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int CTRL_W     = 16;

   localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

   typedef struct packed {
      logic                  valid;
      logic                  reg_write;
      logic                  is_load;
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       op1;
      logic [XLEN-1:0]       op2;
      logic [XLEN-1:0]       imm;
      logic [XLEN-1:0]       pc;
      logic [CTRL_W-1:0]     ctrl;
   } id_ex_t;

   localparam id_ex_t ID_EX_NOP = '0;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Decode-side, bypass and execute-side signals of the ID/EX stage.
// master drives decode and bypass sources; slave is the stage itself.
interface id_ex_operand_stage_if;
   import rv32_pipe_pkg::*;

   logic                  ID_VALID;
   logic [REG_ADDR_W-1:0] ID_RS1;
   logic [REG_ADDR_W-1:0] ID_RS2;
   logic                  ID_USES_RS1;
   logic                  ID_USES_RS2;
   logic [REG_ADDR_W-1:0] ID_RD;
   logic                  ID_REG_WRITE;
   logic                  ID_IS_LOAD;
   logic [XLEN-1:0]       ID_IMM;
   logic [XLEN-1:0]       ID_PC;
   logic [CTRL_W-1:0]     ID_CTRL;
   logic [XLEN-1:0]       RF_DATA1;
   logic [XLEN-1:0]       RF_DATA2;
   logic [XLEN-1:0]       EX_RESULT;
   logic [REG_ADDR_W-1:0] MEM_RD;
   logic                  MEM_REG_WRITE;
   logic [XLEN-1:0]       MEM_WDATA;
   logic [REG_ADDR_W-1:0] WB_RD;
   logic                  WB_REG_WRITE;
   logic [XLEN-1:0]       WB_DATA;
   logic                  EX_READY;
   logic                  FLUSH;
   logic                  ID_STALL;
   logic                  EX_VALID;
   logic                  EX_REG_WRITE;
   logic                  EX_IS_LOAD;
   logic [REG_ADDR_W-1:0] EX_RD;
   logic [XLEN-1:0]       EX_OP1;
   logic [XLEN-1:0]       EX_OP2;
   logic [XLEN-1:0]       EX_IMM;
   logic [XLEN-1:0]       EX_PC;
   logic [CTRL_W-1:0]     EX_CTRL;
   logic [31:0]           LU_STALL_COUNT;

   modport master (
      output ID_VALID, ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2,
      output ID_RD, ID_REG_WRITE, ID_IS_LOAD, ID_IMM, ID_PC, ID_CTRL,
      output RF_DATA1, RF_DATA2, EX_RESULT,
      output MEM_RD, MEM_REG_WRITE, MEM_WDATA,
      output WB_RD, WB_REG_WRITE, WB_DATA, EX_READY, FLUSH,
      input  ID_STALL, EX_VALID, EX_REG_WRITE, EX_IS_LOAD, EX_RD,
      input  EX_OP1, EX_OP2, EX_IMM, EX_PC, EX_CTRL, LU_STALL_COUNT
   );

   modport slave (
      input  ID_VALID, ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2,
      input  ID_RD, ID_REG_WRITE, ID_IS_LOAD, ID_IMM, ID_PC, ID_CTRL,
      input  RF_DATA1, RF_DATA2, EX_RESULT,
      input  MEM_RD, MEM_REG_WRITE, MEM_WDATA,
      input  WB_RD, WB_REG_WRITE, WB_DATA, EX_READY, FLUSH,
      output ID_STALL, EX_VALID, EX_REG_WRITE, EX_IS_LOAD, EX_RD,
      output EX_OP1, EX_OP2, EX_IMM, EX_PC, EX_CTRL, LU_STALL_COUNT
   );

endinterface

// File: rtl/operand_fwd_mux.sv
// One source-operand bypass select: x0, then EX, MEM, WB, else regfile.
// The youngest producer wins, so the case order is significant.
module operand_fwd_mux
   import rv32_pipe_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic                  ex_ok,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic [XLEN-1:0]       ex_data,
   input  logic                  mem_we,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic [XLEN-1:0]       mem_data,
   input  logic                  wb_we,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic [XLEN-1:0]       wb_data,
   input  logic [XLEN-1:0]       rf_data,
   output logic [XLEN-1:0]       op
);

   always_comb begin
      op = rf_data;
      priority case (1'b1)
         (rs == REG_X0):             op = '0;
         (ex_ok  && ex_rd  == rs):   op = ex_data;
         (mem_we && mem_rd == rs):   op = mem_data;
         (wb_we  && wb_rd  == rs):   op = wb_data;
         default:                    op = rf_data;
      endcase
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand bypass, load-use bubble,
// execute backpressure hold, flush and a load-use bubble counter.
module id_ex_operand_stage
   import rv32_pipe_pkg::*;
(
   input logic                  CLK,
   input logic                  RESET,
   id_ex_operand_stage_if.slave bus
);

   id_ex_t          ex_q;
   id_ex_t          ex_d;
   logic [31:0]     lu_cnt;
   logic            ex_fwd_ok;
   logic            rs1_hit;
   logic            rs2_hit;
   logic            lu;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;

   // A load's data is not ready in EX, so it is never bypassed from here.
   assign ex_fwd_ok = ex_q.valid & ex_q.reg_write & ~ex_q.is_load;

   assign rs1_hit = bus.ID_USES_RS1 & (bus.ID_RS1 == ex_q.rd);
   assign rs2_hit = bus.ID_USES_RS2 & (bus.ID_RS2 == ex_q.rd);

   assign lu = bus.ID_VALID & ex_q.valid & ex_q.is_load
             & (ex_q.rd != REG_X0) & (rs1_hit | rs2_hit);

   assign bus.ID_STALL = lu | ~bus.EX_READY;

   operand_fwd_mux u_fwd_rs1 (
      .rs       (bus.ID_RS1),
      .ex_ok    (ex_fwd_ok),
      .ex_rd    (ex_q.rd),
      .ex_data  (bus.EX_RESULT),
      .mem_we   (bus.MEM_REG_WRITE),
      .mem_rd   (bus.MEM_RD),
      .mem_data (bus.MEM_WDATA),
      .wb_we    (bus.WB_REG_WRITE),
      .wb_rd    (bus.WB_RD),
      .wb_data  (bus.WB_DATA),
      .rf_data  (bus.RF_DATA1),
      .op       (op1)
   );

   operand_fwd_mux u_fwd_rs2 (
      .rs       (bus.ID_RS2),
      .ex_ok    (ex_fwd_ok),
      .ex_rd    (ex_q.rd),
      .ex_data  (bus.EX_RESULT),
      .mem_we   (bus.MEM_REG_WRITE),
      .mem_rd   (bus.MEM_RD),
      .mem_data (bus.MEM_WDATA),
      .wb_we    (bus.WB_REG_WRITE),
      .wb_rd    (bus.WB_RD),
      .wb_data  (bus.WB_DATA),
      .rf_data  (bus.RF_DATA2),
      .op       (op2)
   );

   always_comb begin
      ex_d = ID_EX_NOP;
      if (bus.ID_VALID && !bus.FLUSH && !lu) begin
         ex_d.valid     = 1'b1;
         ex_d.reg_write = bus.ID_REG_WRITE;
         ex_d.is_load   = bus.ID_IS_LOAD;
         ex_d.rd        = bus.ID_RD;
         ex_d.op1       = op1;
         ex_d.op2       = op2;
         ex_d.imm       = bus.ID_IMM;
         ex_d.pc        = bus.ID_PC;
         ex_d.ctrl      = bus.ID_CTRL;
      end
   end

   // Backpressure freezes the register and the counter; flush waits for it.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ex_q   <= ID_EX_NOP;
         lu_cnt <= '0;
      end else if (bus.EX_READY) begin
         ex_q <= ex_d;
         if (lu && !bus.FLUSH) lu_cnt <= lu_cnt + 32'd1;
      end
   end

   assign bus.EX_VALID       = ex_q.valid;
   assign bus.EX_REG_WRITE   = ex_q.reg_write;
   assign bus.EX_IS_LOAD     = ex_q.is_load;
   assign bus.EX_RD          = ex_q.rd;
   assign bus.EX_OP1         = ex_q.op1;
   assign bus.EX_OP2         = ex_q.op2;
   assign bus.EX_IMM         = ex_q.imm;
   assign bus.EX_PC          = ex_q.pc;
   assign bus.EX_CTRL        = ex_q.ctrl;
   assign bus.LU_STALL_COUNT = lu_cnt;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: vector table,
// directed hazard sequences and random traffic against a reference model.
module tb_id_ex_operand_stage;
   import rv32_pipe_pkg::*;

   logic CLK = 1'b0;
   logic RESET;
   always #5 CLK = ~CLK;

   id_ex_operand_stage_if bus ();

   id_ex_operand_stage dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   int nvec = 0;
   int nbad = 0;

   typedef struct {
      bit        v;
      bit        rw;
      bit        ld;
      bit [4:0]  rd;
      bit [31:0] op1;
      bit [31:0] op2;
      bit [31:0] imm;
      bit [31:0] pc;
      bit [15:0] ctrl;
   } ex_m_t;

   ex_m_t     m;
   ex_m_t     zero_m;
   bit [31:0] m_cnt;

   typedef struct {
      bit [4:0]  prev_rd;
      bit [4:0]  src_rd;
      bit        mem_we;
      bit        wb_we;
      bit [4:0]  rs1;
      bit [31:0] exp_op1;
   } fwd_vec_t;

   fwd_vec_t tbl[5];

   task automatic chk(string nm, logic [159:0] act, logic [159:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Value of the newest in-flight write to rs, else the regfile value.
   function automatic bit [31:0] newest(bit [4:0] rs, bit [31:0] rf);
      bit        ok[3];
      bit [4:0]  rd[3];
      bit [31:0] d[3];
      ok[0] = m.v && m.rw && !m.ld;  rd[0] = m.rd;       d[0] = bus.EX_RESULT;
      ok[1] = bus.MEM_REG_WRITE;     rd[1] = bus.MEM_RD; d[1] = bus.MEM_WDATA;
      ok[2] = bus.WB_REG_WRITE;      rd[2] = bus.WB_RD;  d[2] = bus.WB_DATA;
      if (rs == 0) return 32'd0;
      for (int i = 0; i < 3; i++)
         if (ok[i] && rd[i] == rs) return d[i];
      return rf;
   endfunction

   function automatic bit load_dep();
      bit need;
      need = (bus.ID_USES_RS1 && bus.ID_RS1 == m.rd)
          || (bus.ID_USES_RS2 && bus.ID_RS2 == m.rd);
      return bus.ID_VALID && m.v && m.ld && m.rd != 0 && need;
   endfunction

   function automatic logic [159:0] act_bundle();
      return {bus.EX_VALID, bus.EX_REG_WRITE, bus.EX_IS_LOAD, bus.EX_RD,
              bus.EX_OP1, bus.EX_OP2, bus.EX_IMM, bus.EX_PC, bus.EX_CTRL};
   endfunction

   function automatic logic [159:0] exp_bundle();
      return {m.v, m.rw, m.ld, m.rd, m.op1, m.op2, m.imm, m.pc, m.ctrl};
   endfunction

   // Inputs are already driven; check stall, clock once, check the bundle.
   task automatic step();
      ex_m_t     nx;
      bit [31:0] ncnt;
      bit        dep;
      #1;
      dep  = load_dep();
      nx   = m;
      ncnt = m_cnt;
      if (!RESET) chk("id_stall", bus.ID_STALL, dep || !bus.EX_READY);
      if (RESET) begin
         nx   = zero_m;
         ncnt = 0;
      end else if (bus.EX_READY) begin
         if (dep && !bus.FLUSH) ncnt = m_cnt + 1;
         if (bus.FLUSH || dep || !bus.ID_VALID) nx = zero_m;
         else begin
            nx.v    = 1;
            nx.rw   = bus.ID_REG_WRITE;
            nx.ld   = bus.ID_IS_LOAD;
            nx.rd   = bus.ID_RD;
            nx.op1  = newest(bus.ID_RS1, bus.RF_DATA1);
            nx.op2  = newest(bus.ID_RS2, bus.RF_DATA2);
            nx.imm  = bus.ID_IMM;
            nx.pc   = bus.ID_PC;
            nx.ctrl = bus.ID_CTRL;
         end
      end
      @(posedge CLK);
      #1;
      m     = nx;
      m_cnt = ncnt;
      chk("ex_bundle", act_bundle(), exp_bundle());
      chk("lu_count", bus.LU_STALL_COUNT, m_cnt);
   endtask

   task automatic idle();
      RESET             = 0;
      bus.ID_VALID      = 0;
      bus.ID_USES_RS1   = 0;
      bus.ID_USES_RS2   = 0;
      bus.ID_REG_WRITE  = 0;
      bus.ID_IS_LOAD    = 0;
      bus.MEM_REG_WRITE = 0;
      bus.WB_REG_WRITE  = 0;
      bus.EX_READY      = 1;
      bus.FLUSH         = 0;
   endtask

   task automatic issue(bit [4:0] rs1, bit [4:0] rs2, bit u1, bit u2,
                        bit [4:0] rd, bit rw, bit ld);
      bus.ID_VALID     = 1;
      bus.ID_RS1       = rs1;
      bus.ID_RS2       = rs2;
      bus.ID_USES_RS1  = u1;
      bus.ID_USES_RS2  = u2;
      bus.ID_RD        = rd;
      bus.ID_REG_WRITE = rw;
      bus.ID_IS_LOAD   = ld;
      bus.ID_IMM       = $urandom;
      bus.ID_PC        = $urandom;
      bus.ID_CTRL      = 16'($urandom);
      bus.RF_DATA1     = $urandom;
      bus.RF_DATA2     = $urandom;
      bus.EX_RESULT    = $urandom;
   endtask

   task automatic drive_rand(int rst_pct);
      issue(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom_range(0, 2) == 0));
      bus.ID_VALID      = $urandom_range(0, 3) != 0;
      bus.MEM_RD        = 5'($urandom_range(0, 7));
      bus.MEM_REG_WRITE = 1'($urandom);
      bus.MEM_WDATA     = $urandom;
      bus.WB_RD         = 5'($urandom_range(0, 7));
      bus.WB_REG_WRITE  = 1'($urandom);
      bus.WB_DATA       = $urandom;
      bus.EX_READY      = $urandom_range(0, 4) != 0;
      bus.FLUSH         = $urandom_range(0, 9) == 0;
      RESET             = $urandom_range(0, 99) < rst_pct;
   endtask

   initial begin
      bit [31:0] a_imm;
      bit [31:0] b_imm;
      bit [31:0] c0;

      tbl[0] = '{5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 32'h11};
      tbl[1] = '{5'd6, 5'd5, 1'b1, 1'b1, 5'd5, 32'h22};
      tbl[2] = '{5'd6, 5'd5, 1'b0, 1'b1, 5'd5, 32'h33};
      tbl[3] = '{5'd6, 5'd5, 1'b0, 1'b0, 5'd5, 32'h44};
      tbl[4] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 32'h0};

      m     = zero_m;
      m_cnt = 0;

      // Reset with random inputs
      for (int i = 0; i < 2; i++) begin
         drive_rand(0);
         RESET        = 1;
         bus.EX_READY = 1;
         step();
      end
      chk("rst_bundle", act_bundle(), 160'd0);
      chk("rst_count", bus.LU_STALL_COUNT, 32'd0);
      idle();
      #1 chk("rst_stall", bus.ID_STALL, 1'b0);

      // Forwarding priority table
      for (int i = 0; i < 5; i++) begin
         idle();
         issue(5'd1, 5'd2, 1'b0, 1'b0, tbl[i].prev_rd, 1'b1, 1'b0);
         step();
         issue(tbl[i].rs1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
         bus.EX_RESULT     = 32'h11;
         bus.MEM_RD        = tbl[i].src_rd;
         bus.MEM_REG_WRITE = tbl[i].mem_we;
         bus.MEM_WDATA     = 32'h22;
         bus.WB_RD         = tbl[i].src_rd;
         bus.WB_REG_WRITE  = tbl[i].wb_we;
         bus.WB_DATA       = 32'h33;
         bus.RF_DATA1      = 32'h44;
         step();
         chk($sformatf("fwd_tbl%0d", i), bus.EX_OP1, tbl[i].exp_op1);
      end

      // Load-use: lw x3 ; add x4,x3,x1
      idle();
      issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1);
      step();
      c0 = m_cnt;
      issue(5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
      #1 chk("lu_stall", bus.ID_STALL, 1'b1);
      step();
      chk("lu_bubble", bus.EX_VALID, 1'b0);
      chk("lu_count1", bus.LU_STALL_COUNT, c0 + 32'd1);
      bus.MEM_RD        = 5'd3;
      bus.MEM_REG_WRITE = 1;
      bus.MEM_WDATA     = 32'hDEADBEEF;
      #1 chk("lu_release", bus.ID_STALL, 1'b0);
      step();
      chk("lu_mem_fwd", bus.EX_OP1, 32'hDEADBEEF);

      idle();
      issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1);
      step();
      issue(5'd3, 5'd1, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0);
      #1 chk("lu_unused", bus.ID_STALL, 1'b0);
      step();

      // Backpressure: three held cycles then capture
      idle();
      issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
      a_imm = bus.ID_IMM;
      step();
      issue(5'd7, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
      b_imm        = bus.ID_IMM;
      bus.EX_READY = 0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("bp_stall", bus.ID_STALL, 1'b1);
         step();
         chk("bp_hold", bus.EX_IMM, a_imm);
      end
      bus.EX_READY = 1;
      step();
      chk("bp_capture", bus.EX_IMM, b_imm);

      // Flush cases
      idle();
      issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
      bus.FLUSH = 1;
      step();
      chk("flush_bubble", bus.EX_VALID, 1'b0);
      idle();
      issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
      a_imm = bus.ID_IMM;
      step();
      issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
      bus.FLUSH    = 1;
      bus.EX_READY = 0;
      step();
      chk("flush_hold", {bus.EX_VALID, bus.EX_IMM}, {1'b1, a_imm});
      idle();
      issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1);
      step();
      issue(5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
      bus.FLUSH = 1;
      c0        = m_cnt;
      step();
      chk("flush_lu", {bus.EX_VALID, bus.LU_STALL_COUNT}, {1'b0, c0});

      // Counter wrap from all-ones
      idle();
      issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1);
      step();
      issue(5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
      force dut.lu_cnt = 32'hFFFF_FFFF;
      #1 release dut.lu_cnt;
      m_cnt = 32'hFFFF_FFFF;
      step();
      chk("cnt_wrap", bus.LU_STALL_COUNT, 32'd0);

      // Reset in the middle of a load-use stall
      idle();
      issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1);
      step();
      issue(5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
      step();
      issue(5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
      bus.EX_READY = 0;
      RESET        = 1;
      step();
      chk("rst_mid", {bus.EX_VALID, bus.LU_STALL_COUNT}, 33'd0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         drive_rand(1);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
